serial_adder_ctrl: RTL and testbench

- Bit-serial adder controller: time-shares one 1-bit full-adder cell across a WIDTH-bit addition, LSB first, one bit per clock.
- Start/done handshake. Operand capture, bit counter, carry register and result assembly are internal.
- Sits between a requester that issues WIDTH-bit add jobs and the single full-adder datapath cell, for area-constrained arithmetic.

---
 rtl/serial_adder_ctrl.sv | 147 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
//-----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder controller. One 1-bit full-adder cell is time-shared across
// a WIDTH-bit addition, LSB first, one bit per clock. A job is accepted with
// start while idle. It runs for WIDTH cycles, then done pulses for one cycle.
//
// Optional build macro: SERIAL_SUB_EN
//   When defined, adds the 'sub' input. sub=1 turns the job into a - b
//   (two's complement; cout=1 means no borrow). Timing is unchanged.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   job request, sampled only in IDLE
//   a, b   in   WIDTH-bit operands, captured on an accepted start
//   cin    in   carry-in for bit 0, captured on an accepted start
//   sub    in   (SERIAL_SUB_EN only) subtract select, captured with operands
//   busy   out  high while a job is in RUN
//   done   out  one-cycle completion pulse
//   sum    out  registered WIDTH-bit result, held until the next completion
//   cout   out  registered carry-out of bit WIDTH-1, held with sum
//-----------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_ps;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_accept;
    logic             w_last;
    logic [1:0]       w_fa;
    logic [WIDTH-1:0] w_ps_next;
    logic [WIDTH-1:0] w_b_cap;
    logic             w_c_cap;

    // Single shared full-adder cell: returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        full_add = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
    endfunction

    // Subtraction is a + ~b + 1, so only the B capture and the initial carry
    // differ between the two modes.
`ifdef SERIAL_SUB_EN
    assign w_b_cap = sub ? ~b : b;
    assign w_c_cap = sub ? 1'b1 : cin;
`else
    assign w_b_cap = b;
    assign w_c_cap = cin;
`endif

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_last    = (r_state == S_RUN) && (r_cnt == LAST_BIT);
    assign w_fa      = full_add(r_a_sh[0], r_b_sh[0], r_carry);
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign w_ps_next = {w_fa[0], r_ps[WIDTH-1:1]};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            // Registered decode keeps busy/done glitch-free at the outputs.
            r_busy  <= (w_next == S_RUN);
            r_done  <= (w_next == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_ps    <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= w_b_cap;
            r_ps    <= '0;
            r_cnt   <= '0;
            r_carry <= w_c_cap;
        end else if (r_state == S_RUN) begin
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_ps    <= w_ps_next;
            r_carry <= w_fa[1];
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_sum  <= w_ps_next;
                r_cout <= w_fa[1];
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

    localparam int W = 8;
`ifdef SERIAL_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub_i = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_SUB_EN
        .sub   (sub_i),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    typedef struct {
        logic [W:0] res;
        int         done_edge;
    } job_t;

    job_t       q[$];
    int         e = 0;          // number of rising edges seen so far
    int         free_edge = 0;  // first edge at which a new start is accepted
    int         last_k = 0;
    bit         have_k = 1'b0;
    logic [W:0] hold = '0;      // {cout,sum} expected to be on the outputs
    int         n_vec = 0;
    int         n_bad = 0;

    function automatic void chk(string nm, logic [W:0] act, logic [W:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %h, expected %h", nm, e, act, exp);
        end
    endfunction

    // Reference model: a job occupies the unit for WIDTH+2 edges; the result
    // is plain integer arithmetic on the captured operands.
    always @(posedge clk) begin
        int v;
        e++;
        if (!rst_n) begin
            q.delete();
            have_k    = 1'b0;
            free_edge = 0;
            hold      = '0;
        end else if (start && e >= free_edge) begin
            if (SUB_EN && sub_i)
                v = int'(a) - int'(b) + (1 << W);
            else
                v = int'(a) + int'(b) + int'(cin);
            q.push_back('{res: (W+1)'(v), done_edge: e + W});
            last_k    = e;
            have_k    = 1'b1;
            free_edge = e + W + 2;
        end
    end

    // Monitor: samples mid-cycle, pops the scoreboard when done is due.
    always @(negedge clk) begin
        logic exp_busy;
        logic exp_done;
        if (!rst_n) begin
            chk("rst_busy", {{W{1'b0}}, busy}, '0);
            chk("rst_done", {{W{1'b0}}, done}, '0);
            chk("rst_result", {cout, sum}, '0);
        end else begin
            exp_busy = have_k && (e >= last_k) && (e <= last_k + W - 1);
            exp_done = (q.size() > 0) && (q[0].done_edge == e);
            chk("busy", {{W{1'b0}}, busy}, {{W{1'b0}}, exp_busy});
            chk("done", {{W{1'b0}}, done}, {{W{1'b0}}, exp_done});
            if (exp_done) begin
                hold = q[0].res;
                void'(q.pop_front());
            end
            chk("result", {cout, sum}, hold);
        end
    end

    task automatic drv(input logic st, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input logic sb);
        @(posedge clk);
        #1;
        start = st;
        a     = av;
        b     = bv;
        cin   = ci;
        sub_i = sb;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(1'b0, W'($urandom()), W'($urandom()), 1'b0, 1'b0);
    endtask

    initial begin
        // Reset held across a few edges, then released mid-cycle.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Basic add, full carry ripple, carry-in ripple.
        drv(1'b1, 8'h5A, 8'h3C, 1'b0, 1'b0); idle(W + 3);
        drv(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0); idle(W + 3);
        drv(1'b1, 8'hFF, 8'h00, 1'b1, 1'b0); idle(W + 3);

        // Requests during RUN and during DONE must be ignored.
        drv(1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
        for (int i = 1; i <= W + 3; i++)
            drv((i == 3) || (i == W + 1), 8'hAA, 8'h55, 1'b0, 1'b0);
        idle(2);

        // Reset mid-job: abort, then a fresh job runs normally.
        drv(1'b1, 8'h80, 8'h80, 1'b0, 1'b0);
        idle(4);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drv(1'b1, 8'h03, 8'h04, 1'b0, 1'b0); idle(W + 3);

        // start held high: back-to-back jobs.
        for (int i = 0; i < 30; i++) drv(1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
        idle(W + 3);

        if (SUB_EN) begin
            drv(1'b1, 8'h10, 8'h01, 1'b0, 1'b1); idle(W + 3);
            drv(1'b1, 8'h00, 8'h01, 1'b1, 1'b1); idle(W + 3);
        end

        // Random traffic, operands changing every cycle.
        for (int i = 0; i < 400; i++)
            drv($urandom_range(0, 2) == 0, W'($urandom()), W'($urandom()),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        idle(W + 4);

        chk("drain", (W+1)'(q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
